// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use / mul-div stalls and EX-redirect squashes.
// Optional performance counters are compiled in when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MD_LATENCY = 8,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] if_id_instruction,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_md_op,
  input  logic        id_md_read,
  input  logic [31:0] id_ex_instruction,
  input  logic        id_ex_dm_r,
  input  logic        ex_redirect,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        md_busy,
  output logic [1:0]  hz_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ACT_RUN      = 2'd0,
    ACT_LU_STALL = 2'd1,
    ACT_MD_STALL = 2'd2,
    ACT_FLUSH    = 2'd3
  } action_t;

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       ex_dest;
  logic             lu_haz;
  logic             md_haz;
  logic             md_accept;
  action_t          action;
  logic [CNT_W-1:0] md_cnt;

  assign id_rs   = if_id_instruction[25:21];
  assign id_rt   = if_id_instruction[20:16];
  assign ex_dest = id_ex_instruction[20:16];

  assign lu_haz = id_ex_dm_r && (ex_dest != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_dest)) ||
                   (id_uses_rt && (id_rt == ex_dest)));

  assign md_busy = (md_cnt != '0);
  assign md_haz  = md_busy && (id_md_read || id_md_op);

  always_comb begin
    action = ACT_RUN;
    if (ex_redirect) begin
      action = ACT_FLUSH;
    end else if (lu_haz) begin
      action = ACT_LU_STALL;
    end else if (md_haz) begin
      action = ACT_MD_STALL;
    end
  end

  // A squashed or stalled mul/div never starts; only a free-running ID issue does.
  assign md_accept = id_md_op && (action == ACT_RUN);

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (action)
      ACT_FLUSH: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      ACT_LU_STALL, ACT_MD_STALL: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_flush = 1'b1;
      end
      default: ;
    endcase
    // Hold the front end and drain bubbles while reset is asserted.
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt   <= '0;
      hz_state <= ACT_RUN;
    end else begin
      hz_state <= action;
      if (md_accept) begin
        md_cnt <= CNT_W'(MD_LATENCY);
      end else if (md_cnt != '0) begin
        md_cnt <= md_cnt - 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if ((action == ACT_LU_STALL) || (action == ACT_MD_STALL)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (action == ACT_FLUSH) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expectations queued at drive time, outputs
// captured mid-cycle and compared per test. Perf counters checked under HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam int MD_LATENCY = 8;

  localparam logic [3:0] C_RUN   = 4'b1100;
  localparam logic [3:0] C_STALL = 4'b0001;
  localparam logic [3:0] C_FLUSH = 4'b1111;
  localparam logic [3:0] C_RST   = 4'b0011;

  localparam logic [1:0] A_RUN = 2'd0;
  localparam logic [1:0] A_LU  = 2'd1;
  localparam logic [1:0] A_MD  = 2'd2;
  localparam logic [1:0] A_FL  = 2'd3;

  logic        clk;
  logic        reset;
  logic [31:0] if_id_instruction;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_md_op;
  logic        id_md_read;
  logic [31:0] id_ex_instruction;
  logic        id_ex_dm_r;
  logic        ex_redirect;
  logic        pc_write;
  logic        if_id_write;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        md_busy;
  logic [1:0]  hz_state;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  // {pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, hz_state}
  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  logic [1:0] last_act;
  int         checks;
  int         failures;

  hazard_ctrl #(.MD_LATENCY(MD_LATENCY), .CNT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_id_instruction(if_id_instruction),
    .id_uses_rs       (id_uses_rs),
    .id_uses_rt       (id_uses_rt),
    .id_md_op         (id_md_op),
    .id_md_read       (id_md_read),
    .id_ex_instruction(id_ex_instruction),
    .id_ex_dm_r       (id_ex_dm_r),
    .ex_redirect      (ex_redirect),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_flush      (id_ex_flush),
    .md_busy          (md_busy),
    .hz_state         (hz_state)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pipeline cycle: drive after the edge, queue the expectation, capture at negedge.
  task automatic apply(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                       input logic u_rs, input logic u_rt, input logic md_op,
                       input logic md_rd, input logic [4:0] dest, input logic dm_r,
                       input logic redir, input logic [3:0] e_ctrl, input logic e_busy,
                       input logic [1:0] act);
    reset             = rst;
    if_id_instruction = {6'd0, rs, rt, 16'h0020};
    id_uses_rs        = u_rs;
    id_uses_rt        = u_rt;
    id_md_op          = md_op;
    id_md_read        = md_rd;
    id_ex_instruction = {6'h23, 5'd1, dest, 16'h0000};
    id_ex_dm_r        = dm_r;
    ex_redirect       = redir;
    exp_q.push_back({e_ctrl, e_busy, last_act});
    last_act = act;
    @(negedge clk);
    obs_q.push_back({pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, hz_state});
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic [3:0] e_ctrl, input logic e_busy);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, e_ctrl, e_busy, A_RUN);
  endtask

  task automatic test_reset();
    last_act = A_RUN;
    apply(1'b0, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, C_RST, 1'b0, A_RUN);
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, C_RST, 1'b0, A_RUN);
    nop(C_RUN, 1'b0);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_load_use();
    apply(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b0, C_STALL, 1'b0, A_LU);
    apply(1'b1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    nop(C_RUN, 1'b0);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL load_use cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_md_stall();
    apply(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    for (int k = 0; k < MD_LATENCY; k++) begin
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_STALL, 1'b1, A_MD);
    end
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    nop(C_RUN, 1'b0);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL md_stall cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_redirect();
    apply(1'b1, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1, C_FLUSH, 1'b0, A_FL);
    nop(C_RUN, 1'b0);
    nop(C_RUN, 1'b0);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL redirect cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_perf();
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cycles !== 32'd9) begin
      failures++;
      $display("FAIL perf_stall_cycles: got %0d, expected 9", stall_cycles);
    end
    checks++;
    if (flush_count !== 32'd1) begin
      failures++;
      $display("FAIL perf_flush_count: got %0d, expected 1", flush_count);
    end
`endif
  endtask

  task automatic test_operands();
    // rt match, rs match with uses_rs off, load to $0, no-load with match
    apply(1'b1, 5'd1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, C_STALL, 1'b0, A_LU);
    apply(1'b1, 5'd7, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, C_RUN, 1'b0, A_RUN);
    apply(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, C_RUN, 1'b0, A_RUN);
    apply(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    apply(1'b1, 5'd31, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, C_STALL, 1'b0, A_LU);
    nop(C_RUN, 1'b0);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL operands cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_squash_md();
    apply(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, C_FLUSH, 1'b0, A_FL);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL squash_md cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_md();
    apply(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    nop(C_RUN, 1'b1);
    nop(C_RUN, 1'b1);
    nop(C_RUN, 1'b1);
    // md_cnt is 5 here; asynchronous reset must clear it before the next edge
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_RST, 1'b0, A_RUN);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_mid_md cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_redirect_during_md();
    apply(1'b1, 5'd8, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, C_FLUSH, 1'b1, A_FL);
    for (int k = 0; k < MD_LATENCY - 1; k++) begin
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_STALL, 1'b1, A_MD);
    end
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, C_RUN, 1'b0, A_RUN);
    for (int i = 0; obs_q.size() > 0; i++) begin
      logic [6:0] e, o;
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL redirect_during_md cyc%0d: got ctrl=%b busy=%b hz=%0d, expected ctrl=%b busy=%b hz=%0d",
                 i, o[6:3], o[2], o[1:0], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  initial begin
    checks            = 0;
    failures          = 0;
    last_act          = A_RUN;
    reset             = 1'b0;
    if_id_instruction = '0;
    id_uses_rs        = 1'b0;
    id_uses_rt        = 1'b0;
    id_md_op          = 1'b0;
    id_md_read        = 1'b0;
    id_ex_instruction = '0;
    id_ex_dm_r        = 1'b0;
    ex_redirect       = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_md_stall();
    test_redirect();
    test_perf();
    test_operands();
    test_squash_md();
    test_reset_mid_md();
    test_redirect_during_md();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
